prio_encoder_reg: RTL and testbench
===================================

Name: prio_encoder_reg

Overview:
- Parametrised N-to-log2(N) priority encoder with a registered output and a valid/ready handshake.
- Successor to the fixed 4-input combinational encoder.
- Adds:
  - generic width
  - multi-request flag
  - backpressure-safe output register
  - optional rotating (round-robin) priority
- Sits between request-generating logic (interrupt lines, channel requests) and a downstream consumer that may stall.

Parameters:
N, 8, number of request inputs; must be a power of 2 and at least 2.
W, 3, output index width; must equal log2(N).

Ports:
clk  input  1  single clock; all state changes on rising edge.
rst_n  input  1  synchronous reset, active-low.
en  input  1  encode enable; when 0, no new capture.
req  input  N  request vector; bit i set = request on channel i.
out_ready  input  1  consumer accepts the current output this cycle.
out_valid  output  1  out_idx/out_multi hold a valid encode.
out_idx  output  W  index of the granted request.
out_multi  output  1  more than one req bit was set at capture.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-low. Sampled only on the rising edge of clk.
  - On reset: out_valid=0, out_idx=0, out_multi=0, priority pointer ptr=N-1.
  - Reset mid-transfer discards any held output. No capture occurs in the reset cycle.
- Handshake:
  - Define slot_free = !out_valid || out_ready.
  - Define capture = en && (req != 0) && slot_free.
- Capture cycle: the next edge loads:
  - out_valid=1
  - out_idx = index of the winning set bit of req
  - out_multi = 1 if popcount(req) >= 2, else 0
  - Latency is one cycle from req sampled to out_valid.
- Priority, fixed mode: the highest set index wins (bit N-1 highest, bit 0 lowest).
- Hold rule: while out_valid && !out_ready, out_valid, out_idx and out_multi are held stable regardless of req or en. No request is lost from the register; req is level-sampled, not latched.
- Accept without recapture: if out_valid && out_ready && !capture, the next edge sets out_valid=0. out_idx and out_multi keep their last values, which are don't-care.
- Accept with recapture: if out_valid && out_ready && capture, the new encode replaces the old one in the same edge. out_valid stays 1, giving back-to-back throughput of 1 per cycle.
- en=0 or req==0: no capture. An existing output is still drained normally by out_ready.
- out_ready while out_valid=0: ignored.
- Outputs are driven only from registers; there is no combinational path from req to outputs.
- Width rule: out_idx is always in 0..N-1. Index arithmetic is modulo N.

Optional Feature:
- Macro: PRIO_ENC_ROUND_ROBIN_EN.
- Defined:
  - The search starts at ptr and proceeds downward with wrap: ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
  - The first set bit found wins.
  - On every capture of index k, ptr <= (k-1) mod N. The just-served channel becomes lowest priority.
  - ptr changes only on capture, never on hold or drain.
  - out_multi semantics are unchanged.
- Not defined:
  - ptr logic is absent and priority is fixed MSB-first.
  - Behaviour is identical to the defined case with ptr permanently N-1.

Test Plan:
1. rst_n=0 for 2 cycles with req=8'hFF, en=1, out_ready=1 -> out_valid=0, out_idx=0, out_multi=0 throughout. First capture occurs on the edge after rst_n=1.
2. en=1, out_ready=1, req=8'b0000_0001 for one cycle, then req=0 -> one cycle later out_valid=1, out_idx=0, out_multi=0. The cycle after that, out_valid=0.
3. en=1, out_ready=1, req=8'b0010_1100 held -> out_idx=5, out_multi=1 every cycle, out_valid continuously 1.
4. Backpressure:
   - Stimulus: req=8'h04 captured, then out_ready=0 for 3 cycles while req=8'h80, then out_ready=1.
   - Response: out_idx=2 held for all 3 stall cycles. On the edge where out_ready=1, out_idx=7 and out_valid remains 1.
5. en=0, req=8'hFF, out_ready=1 with a held output pending -> pending output drains and out_valid=0 the next cycle. No new capture while en=0.
6. req=8'hFF, en=1, out_ready=1 for 10 cycles:
   - With PRIO_ENC_ROUND_ROBIN_EN: out_idx sequence is 7,6,5,4,3,2,1,0,7,6.
   - Without: out_idx is 7 on every cycle.
   - Repeat with out_ready=0 for 2 cycles mid-sequence: the sequence is paused and not skipped.

Source files
------------

// File: rtl/prio_encoder_reg.sv
// Registered N-to-log2(N) priority encoder with a valid/ready output slot.
// Define PRIO_ENC_ROUND_ROBIN_EN for rotating priority; the default build is fixed MSB-first.
module prio_encoder_reg #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_multi
);

  // Handshake: the output slot holds one encode; it is consumed on a cycle
  // where out_valid && out_ready, and may be refilled on that same edge.

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic         multi_q, multi_d;

  logic         slot_free;
  logic         capture;
  logic [W-1:0] search_start;
  logic [W-1:0] win_idx;
  logic [W-1:0] cand;
  logic         found;
  logic         req_multi;

  assign slot_free = !valid_q || out_ready;
  assign capture   = en && (req != '0) && slot_free;
  assign req_multi = (req & (req - N'(1))) != '0;

  // Walk downward from search_start with wrap; W-bit arithmetic gives modulo N.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int j = 0; j < N; j++) begin
      cand = search_start - W'(j);
      if (!found && req[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;

  assign search_start = ptr_q;

  // The channel just served drops to lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (capture) ptr_d = win_idx - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= W'(N - 1);
    else        ptr_q <= ptr_d;
  end
`else
  assign search_start = W'(N - 1);
`endif

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    if (capture) begin
      valid_d = 1'b1;
      idx_d   = win_idx;
      multi_d = req_multi;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      multi_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      multi_q <= multi_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_multi = multi_q;

endmodule

// File: tb/tb_prio_encoder_reg.sv
// Cycle-by-cycle vector table for prio_encoder_reg, with per-row expectations
// for both fixed and round-robin (PRIO_ENC_ROUND_ROBIN_EN) builds.
module tb_prio_encoder_reg;

  localparam int N = 8;
  localparam int W = 3;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic         out_multi;

  int n_checks;
  int n_fail;

  prio_encoder_reg #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_multi (out_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs held across one rising edge, then the expected register state.
  typedef struct {
    logic         rst_n;
    logic         en;
    logic [N-1:0] req;
    logic         rdy;
    logic         exp_v;
    logic [W-1:0] idx_fix;
    logic [W-1:0] idx_rr;
    logic         exp_m;
    logic         chk_data;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic e, input logic [N-1:0] q, input logic rd,
                     input logic v, input logic [W-1:0] i_f, input logic [W-1:0] i_r,
                     input logic m, input logic cd);
    vec_t x;
    x.rst_n = r; x.en = e; x.req = q; x.rdy = rd;
    x.exp_v = v; x.idx_fix = i_f; x.idx_rr = i_r; x.exp_m = m; x.chk_data = cd;
    vt.push_back(x);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0d, want %0d", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [N-1:0] q, input logic rd);
    rst_n = r; en = e; req = q; out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; en = 1'b0; req = '0; out_ready = 1'b0;

    //   rst en  req    rdy  v  fix rr  m  chk
    // Reset held two cycles with all requests pending.
    add(0, 1, 8'hFF, 1,   0, 0, 0,  0, 1);
    add(0, 1, 8'hFF, 1,   0, 0, 0,  0, 1);
    // Single-cycle request on bit 0, then idle.
    add(1, 1, 8'h01, 1,   1, 0, 0,  0, 1);
    add(1, 1, 8'h00, 1,   0, 0, 0,  0, 0);
    // 0010_1100 held: fixed always 5; rotating walks 5,3,2,5.
    add(1, 1, 8'h2C, 1,   1, 5, 5,  1, 1);
    add(1, 1, 8'h2C, 1,   1, 5, 3,  1, 1);
    add(1, 1, 8'h2C, 1,   1, 5, 2,  1, 1);
    add(1, 1, 8'h2C, 1,   1, 5, 5,  1, 1);
    add(0, 0, 8'h00, 0,   0, 0, 0,  0, 1);
    // Backpressure: index 2 held through three stalls, then 7 replaces it.
    add(1, 1, 8'h04, 1,   1, 2, 2,  0, 1);
    add(1, 1, 8'h80, 0,   1, 2, 2,  0, 1);
    add(1, 1, 8'h80, 0,   1, 2, 2,  0, 1);
    add(1, 1, 8'h80, 0,   1, 2, 2,  0, 1);
    add(1, 1, 8'h80, 1,   1, 7, 7,  0, 1);
    // Stall again, then drain with en=0; no capture afterwards.
    add(1, 1, 8'hFF, 0,   1, 7, 7,  0, 1);
    add(1, 0, 8'hFF, 1,   0, 0, 0,  0, 0);
    add(1, 0, 8'hFF, 1,   0, 0, 0,  0, 0);
    add(0, 0, 8'h00, 0,   0, 0, 0,  0, 1);
    // All requests for ten cycles.
    add(1, 1, 8'hFF, 1,   1, 7, 7,  1, 1);
    add(1, 1, 8'hFF, 1,   1, 7, 6,  1, 1);
    add(1, 1, 8'hFF, 1,   1, 7, 5,  1, 1);
    add(1, 1, 8'hFF, 1,   1, 7, 4,  1, 1);
    add(1, 1, 8'hFF, 1,   1, 7, 3,  1, 1);
    add(1, 1, 8'hFF, 1,   1, 7, 2,  1, 1);
    add(1, 1, 8'hFF, 1,   1, 7, 1,  1, 1);
    add(1, 1, 8'hFF, 1,   1, 7, 0,  1, 1);
    add(1, 1, 8'hFF, 1,   1, 7, 7,  1, 1);
    add(1, 1, 8'hFF, 1,   1, 7, 6,  1, 1);
    // Two-cycle stall pauses the rotation rather than skipping.
    add(1, 1, 8'hFF, 0,   1, 7, 6,  1, 1);
    add(1, 1, 8'hFF, 0,   1, 7, 6,  1, 1);
    add(1, 1, 8'hFF, 1,   1, 7, 5,  1, 1);
    add(1, 1, 8'hFF, 1,   1, 7, 4,  1, 1);
    // req==0 drains the slot.
    add(1, 1, 8'h00, 1,   0, 0, 0,  0, 0);

    foreach (vt[i]) begin
      drive(vt[i].rst_n, vt[i].en, vt[i].req, vt[i].rdy);
      check("out_valid", i, 32'(out_valid), 32'(vt[i].exp_v));
      if (vt[i].chk_data) begin
        check("out_idx", i, 32'(out_idx), RR ? 32'(vt[i].idx_rr) : 32'(vt[i].idx_fix));
        check("out_multi", i, 32'(out_multi), 32'(vt[i].exp_m));
      end
    end

    // Reset while an output is stalled discards it; first edge after reset captures.
    drive(0, 0, 8'h00, 0);
    drive(1, 1, 8'h18, 0);
    check("seq_stall_valid", 100, 32'(out_valid), 32'd1);
    check("seq_stall_idx", 100, 32'(out_idx), 32'd4);
    check("seq_stall_multi", 100, 32'(out_multi), 32'd1);
    drive(0, 1, 8'h18, 0);
    check("seq_rst_discard_valid", 101, 32'(out_valid), 32'd0);
    check("seq_rst_discard_idx", 101, 32'(out_idx), 32'd0);
    drive(1, 1, 8'h02, 0);
    check("seq_post_rst_valid", 102, 32'(out_valid), 32'd1);
    check("seq_post_rst_idx", 102, 32'(out_idx), 32'd1);
    check("seq_post_rst_multi", 102, 32'(out_multi), 32'd0);
    // Stalled slot ignores en toggling and request changes.
    drive(1, 0, 8'h40, 0);
    check("seq_hold_idx", 103, 32'(out_idx), 32'd1);
    drive(1, 1, 8'h40, 1);
    check("seq_recap_valid", 104, 32'(out_valid), 32'd1);
    check("seq_recap_idx", 104, 32'(out_idx), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
